// File: rtl/eca_pkg.sv
// rtl/eca_pkg.sv - shared types for the ECA memory arbiter
package eca_pkg;

  localparam int NUM_CLIENTS = 3;

  typedef enum logic [1:0] {
    CL_WR = 2'd0,
    CL_BM = 2'd1,
    CL_IB = 2'd2
  } client_e;

  typedef struct packed {
    logic    valid;
    client_e id;
  } tag_t;

endpackage

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - combinational 3-way round-robin grant starting at ptr_i
module rr_arb3
  import eca_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [1:0]             ptr_i,
  output logic [NUM_CLIENTS-1:0] gnt_o
);

  logic [1:0] idx;

  always_comb begin
    gnt_o = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = 2'((int'(ptr_i) + k) % NUM_CLIENTS);
      if (gnt_o == '0 && req_i[idx]) gnt_o[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/eca_mem_arb.sv
// rtl/eca_mem_arb.sv - round-robin arbiter sharing one SRAM between three clients
module eca_mem_arb
  import eca_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int MEM_RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_en,
  input  logic              flush,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              bm_rd_req,
  input  logic [ADDR_W-1:0] bm_rd_addr,
  output logic              bm_rd_gnt,
  output logic [DATA_W-1:0] bm_rd_data,
  output logic              bm_rd_val,
  input  logic              ib_rd_req,
  input  logic [ADDR_W-1:0] ib_rd_addr,
  output logic              ib_rd_gnt,
  output logic [DATA_W-1:0] ib_rd_data,
  output logic              ib_rd_val,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int DEPTH = MEM_RD_LAT + 1;

  logic [NUM_CLIENTS-1:0] req;
  logic [NUM_CLIENTS-1:0] gnt;
  logic [1:0]             ptr_q, ptr_d;
  logic                   mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  tag_t [DEPTH-1:0]       tag_q;
  tag_t                   tag_in;
  tag_t                   head;
  logic                   head_ok;
  logic                   tag_any;

  assign req = {ib_rd_req, bm_rd_req, wr_req} & {NUM_CLIENTS{arb_en & ~rst & ~flush}};

  rr_arb3 u_rr_arb3 (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign wr_gnt    = gnt[0];
  assign bm_rd_gnt = gnt[1];
  assign ib_rd_gnt = gnt[2];

  always_comb begin
    ptr_d        = ptr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    tag_in.valid = gnt[1] | gnt[2];
    tag_in.id    = gnt[2] ? CL_IB : CL_BM;
    if (flush)       ptr_d = 2'd0;
    else if (gnt[0]) ptr_d = 2'd1;
    else if (gnt[1]) ptr_d = 2'd2;
    else if (gnt[2]) ptr_d = 2'd0;
    if (gnt[0]) begin
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end else if (gnt[1]) begin
      mem_addr_d  = bm_rd_addr;
    end else if (gnt[2]) begin
      mem_addr_d  = ib_rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mem_en_q    <= |gnt;
      mem_we_q    <= gnt[0];
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (flush) tag_q <= '0;
      else       tag_q <= {tag_q[DEPTH-2:0], tag_in};
    end
  end

  // Head of the tag pipe lines up with mem_rdata; a flush or reset kills the return.
  always_comb begin
    head    = tag_q[DEPTH-1];
    head_ok = head.valid & ~rst & ~flush;
    tag_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) tag_any = tag_any | tag_q[i].valid;
  end

  assign bm_rd_val  = head_ok & (head.id == CL_BM);
  assign ib_rd_val  = head_ok & (head.id == CL_IB);
  assign bm_rd_data = mem_rdata;
  assign ib_rd_data = mem_rdata;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = ~rst & (mem_en_q | tag_any);

endmodule

// File: tb/tb_eca_mem_arb.sv
// tb/tb_eca_mem_arb.sv - self-checking bench for eca_mem_arb
module tb_eca_mem_arb;

  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst, arb_en, flush;
  logic          wr_req, bm_rd_req, ib_rd_req;
  logic [AW-1:0] wr_addr, bm_rd_addr, ib_rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt, bm_rd_gnt, ib_rd_gnt;
  logic [DW-1:0] bm_rd_data, ib_rd_data;
  logic          bm_rd_val, ib_rd_val;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  eca_mem_arb dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .flush(flush),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .bm_rd_req(bm_rd_req), .bm_rd_addr(bm_rd_addr), .bm_rd_gnt(bm_rd_gnt),
    .bm_rd_data(bm_rd_data), .bm_rd_val(bm_rd_val),
    .ib_rd_req(ib_rd_req), .ib_rd_addr(ib_rd_addr), .ib_rd_gnt(ib_rd_gnt),
    .ib_rd_data(ib_rd_data), .ib_rd_val(ib_rd_val),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 5) return 64'hA5A5;
    return 64'hD000_0000_0000_0000 | 64'(a * 3);
  endfunction

  // SRAM with two cycles of read latency from the registered strobe
  logic          tb_init = 1'b1;
  logic [DW-1:0] sram [1024];
  logic [DW-1:0] rd1, rd2;
  assign mem_rdata = rd2;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      if (mem_en) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        else        rd1 <= sram[mem_addr];
      end
      rd2 <= rd1;
    end
  end

  // Reference model: expected responses with due cycle and data known at grant time
  typedef struct {
    int            due;
    int            cl;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         sched[$];
  logic [DW-1:0] shadow [1024];
  int            ptr_m;
  logic          exp_men, exp_mwe;
  logic [AW-1:0] exp_maddr;
  logic [DW-1:0] exp_mwdata;
  int            cyc;
  int            checks;
  int            errors;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic run_cycle(input logic tbl, input logic [2:0] tg, input logic [1:0] tv,
                           input logic tb, input logic [DW-1:0] td, output logic [2:0] eg);
    logic [2:0]    reqv;
    logic [1:0]    ev;
    logic [DW-1:0] ed;
    logic          eb;
    resp_t         keep[$];
    @(negedge clk);
    reqv = {ib_rd_req, bm_rd_req, wr_req};
    eg   = 3'b000;
    if (!rst && arb_en && !flush)
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (ptr_m + k) % 3;
        if (eg == 3'b000 && reqv[c]) eg[c] = 1'b1;
      end
    eb = !rst && (exp_men || sched.size() > 0);
    ev = 2'b00;
    ed = '0;
    foreach (sched[i])
      if (sched[i].due == cyc && !rst && !flush) begin
        ev[sched[i].cl - 1] = 1'b1;
        ed = sched[i].data;
      end

    chk("gnt", 64'({ib_rd_gnt, bm_rd_gnt, wr_gnt}), 64'(eg));
    chk("val", 64'({ib_rd_val, bm_rd_val}), 64'(ev));
    chk("busy", 64'(busy), 64'(eb));
    if (ev[0]) chk("bm_data", bm_rd_data, ed);
    if (ev[1]) chk("ib_data", ib_rd_data, ed);
    if (cyc > 0) begin
      chk("mem_en", 64'(mem_en), 64'(exp_men));
      chk("mem_addr", 64'(mem_addr), 64'(exp_maddr));
      chk("mem_wdata", mem_wdata, exp_mwdata);
      if (exp_men) chk("mem_we", 64'(mem_we), 64'(exp_mwe));
    end
    if (tbl) begin
      chk("tbl_gnt", 64'({ib_rd_gnt, bm_rd_gnt, wr_gnt}), 64'(tg));
      chk("tbl_val", 64'({ib_rd_val, bm_rd_val}), 64'(tv));
      chk("tbl_busy", 64'(busy), 64'(tb));
      if (tv[0]) chk("tbl_bm_data", bm_rd_data, td);
      if (tv[1]) chk("tbl_ib_data", ib_rd_data, td);
    end

    foreach (sched[i]) if (sched[i].due > cyc) keep.push_back(sched[i]);
    sched = keep;
    if (rst) begin
      sched.delete();
      ptr_m = 0; exp_men = 0; exp_mwe = 0; exp_maddr = '0; exp_mwdata = '0;
    end else if (flush) begin
      sched.delete();
      ptr_m = 0; exp_men = 0; exp_mwe = 0;
    end else begin
      exp_men = |eg;
      exp_mwe = eg[0];
      for (int c = 0; c < 3; c++) if (eg[c]) ptr_m = (c + 1) % 3;
      if (eg[0]) begin
        shadow[wr_addr] = wr_data;
        exp_maddr  = wr_addr;
        exp_mwdata = wr_data;
      end else if (eg[1]) begin
        exp_maddr = bm_rd_addr;
        sched.push_back('{cyc + 3, 1, shadow[bm_rd_addr]});
      end else if (eg[2]) begin
        exp_maddr = ib_rd_addr;
        sched.push_back('{cyc + 3, 2, shadow[ib_rd_addr]});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic          r, en, fl;
    logic [2:0]    req;
    logic [DW-1:0] wd;
    logic [2:0]    g;
    logic [1:0]    v;
    logic          b;
    logic [DW-1:0] d;
  } vec_t;

  vec_t tbl[31];

  initial begin
    @(posedge clk);
    #2 tb_init = 1'b0;
  end

  initial begin
    logic [2:0] eg;
    logic [2:0] rq;
    checks = 0; errors = 0; cyc = 0;
    ptr_m = 0; exp_men = 0; exp_mwe = 0; exp_maddr = '0; exp_mwdata = '0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);

    //         rst en fl  req     wd       gnt     val    busy data
    tbl[0]  = '{1, 1, 0, 3'b111, 64'h1234, 3'b000, 2'b00, 0, 64'h0};
    tbl[1]  = '{1, 1, 0, 3'b111, 64'h1234, 3'b000, 2'b00, 0, 64'h0};
    tbl[2]  = '{0, 1, 0, 3'b111, 64'h1234, 3'b001, 2'b00, 0, 64'h0};
    tbl[3]  = '{0, 1, 0, 3'b111, 64'h1234, 3'b010, 2'b00, 1, 64'h0};
    tbl[4]  = '{0, 1, 0, 3'b111, 64'h1234, 3'b100, 2'b00, 1, 64'h0};
    tbl[5]  = '{0, 1, 0, 3'b111, 64'h1234, 3'b001, 2'b00, 1, 64'h0};
    tbl[6]  = '{0, 1, 0, 3'b000, 64'h1234, 3'b000, 2'b01, 1, 64'hA5A5};
    tbl[7]  = '{0, 1, 0, 3'b000, 64'h1234, 3'b000, 2'b10, 1, 64'h1234};
    tbl[8]  = '{0, 1, 0, 3'b000, 64'h1234, 3'b000, 2'b00, 0, 64'h0};
    tbl[9]  = '{0, 1, 0, 3'b110, 64'h1234, 3'b010, 2'b00, 0, 64'h0};
    tbl[10] = '{0, 1, 0, 3'b110, 64'h1234, 3'b100, 2'b00, 1, 64'h0};
    tbl[11] = '{0, 1, 0, 3'b110, 64'h1234, 3'b010, 2'b00, 1, 64'h0};
    tbl[12] = '{0, 1, 0, 3'b110, 64'h1234, 3'b100, 2'b01, 1, 64'hA5A5};
    tbl[13] = '{0, 1, 1, 3'b000, 64'h1234, 3'b000, 2'b00, 1, 64'h0};
    tbl[14] = '{0, 1, 0, 3'b000, 64'h1234, 3'b000, 2'b00, 0, 64'h0};
    tbl[15] = '{0, 1, 0, 3'b111, 64'h1234, 3'b001, 2'b00, 0, 64'h0};
    tbl[16] = '{0, 1, 0, 3'b110, 64'h1234, 3'b010, 2'b00, 1, 64'h0};
    tbl[17] = '{0, 0, 0, 3'b110, 64'h1234, 3'b000, 2'b00, 1, 64'h0};
    tbl[18] = '{0, 0, 0, 3'b110, 64'h1234, 3'b000, 2'b00, 1, 64'h0};
    tbl[19] = '{0, 0, 0, 3'b110, 64'h1234, 3'b000, 2'b01, 1, 64'hA5A5};
    tbl[20] = '{0, 1, 0, 3'b110, 64'h1234, 3'b100, 2'b00, 0, 64'h0};
    tbl[21] = '{0, 1, 0, 3'b000, 64'h1234, 3'b000, 2'b00, 1, 64'h0};
    tbl[22] = '{0, 1, 0, 3'b000, 64'h1234, 3'b000, 2'b00, 1, 64'h0};
    tbl[23] = '{0, 1, 0, 3'b000, 64'h1234, 3'b000, 2'b10, 1, 64'h1234};
    tbl[24] = '{0, 1, 0, 3'b000, 64'h1234, 3'b000, 2'b00, 0, 64'h0};
    tbl[25] = '{0, 1, 0, 3'b001, 64'h5678, 3'b001, 2'b00, 0, 64'h0};
    tbl[26] = '{0, 1, 0, 3'b100, 64'h5678, 3'b100, 2'b00, 1, 64'h0};
    tbl[27] = '{0, 1, 0, 3'b000, 64'h5678, 3'b000, 2'b00, 1, 64'h0};
    tbl[28] = '{0, 1, 0, 3'b000, 64'h5678, 3'b000, 2'b00, 1, 64'h0};
    tbl[29] = '{0, 1, 0, 3'b000, 64'h5678, 3'b000, 2'b10, 1, 64'h5678};
    tbl[30] = '{0, 1, 0, 3'b000, 64'h5678, 3'b000, 2'b00, 0, 64'h0};

    wr_addr = 10'h3; bm_rd_addr = 10'h5; ib_rd_addr = 10'h3;
    for (int i = 0; i < 31; i++) begin
      rst = tbl[i].r; arb_en = tbl[i].en; flush = tbl[i].fl;
      {ib_rd_req, bm_rd_req, wr_req} = tbl[i].req;
      wr_data = tbl[i].wd;
      run_cycle(1'b1, tbl[i].g, tbl[i].v, tbl[i].b, tbl[i].d, eg);
    end

    // Randomized traffic: clients hold request and address until granted
    rq = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 199) == 0);
      flush  = ($urandom_range(0, 39) == 0);
      arb_en = ($urandom_range(0, 7) != 0);
      {ib_rd_req, bm_rd_req, wr_req} = rq;
      run_cycle(1'b0, 3'b000, 2'b00, 1'b0, '0, eg);
      for (int c = 0; c < 3; c++)
        if (eg[c] || !rq[c]) begin
          rq[c] = (eg[c] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0));
          if (c == 0) begin
            wr_addr = 10'($urandom_range(0, 15));
            wr_data = {$urandom, $urandom};
          end
          if (c == 1) bm_rd_addr = 10'($urandom_range(0, 15));
          if (c == 2) ib_rd_addr = 10'($urandom_range(0, 15));
        end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
